score_display_ctrl: RTL and testbench
=====================================

# score_display_ctrl

Sequencing controller for the two-digit score display of the game. It accepts a binary score from the game core and converts it to BCD with an iterative double-dabble FSM. It drives the tens and ones seven-segment digits (`ss1`, `ss0`) with leading-zero blanking. While `game_over` is high, it flashes the display at a rate set by a parameterised prescaler.

## Interface
- `BLINK_DIV`, default 6_000_000. Prescaler period in clocks for each blink phase (0.5 s at 12 MHz). Legal range ≥ 2. Counter width is `$clog2(BLINK_DIV)`.
- `clk  in  1` System clock (hwclk domain).
- `reset  in  1` Asynchronous, active-low reset. Asserted at 0.
- `score_in  in  7` Binary score. Values above 99 saturate to 99.
- `score_load  in  1` Single-cycle request to latch `score_in`. Honoured only in IDLE.
- `game_over  in  1` Level input that enables blinking.
- `ss0  out  8` Ones digit, segments a..g on bits 0..6, dp on bit 7, active-high.
- `ss1  out  8` Tens digit, same encoding.
- `busy  out  1` High while a conversion is in flight.

## Operation
- FSM states:
  - **IDLE:** on `score_load`, capture `min(score_in, 99)` into the shift register, clear the BCD field and the iteration counter, then go to CONV.
  - **CONV:** perform one double-dabble step per clock. Add 3 to each BCD nibble ≥ 5, then shift left by 1. After 7 steps (counter 0..6) go to LATCH.
  - **LATCH:** copy the BCD nibbles into the `tens_q` and `ones_q` display registers, then go to IDLE.
- `busy` = (state != IDLE).
- `score_load` in CONV or LATCH is dropped. There is no queueing and no error flag.
- Segment LUT, digits 0–9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex). Bit 7 (dp) is always 0.
- Leading-zero blanking: when `tens_q == 0`, `ss1 = 8'h00`. `ss0` always shows its digit, including 0.
- Blink logic:
  - When `game_over == 0`, the prescaler and `blink_phase` are held at 0.
  - When `game_over == 1`, the prescaler counts 0..BLINK_DIV-1. On wrap it toggles `blink_phase`.
  - `blink_phase == 1` forces `ss0 = ss1 = 8'h00`.
  - Deasserting `game_over` clears both the prescaler and the phase on the next edge, so the digits reappear immediately.
- `ss0` and `ss1` are combinational decodes of `tens_q`, `ones_q` and `blink_phase`. All state lives in flops.

## Timing
- Reset values:
  - state IDLE; `tens_q = ones_q = 0`; prescaler 0; `blink_phase` 0.
  - Outputs: `ss0 = 8'h3F`, `ss1 = 8'h00`, `busy = 0`.
- Load latency:
  - `score_load` sampled at edge N puts the FSM in CONV at N.
  - The 7 conversion steps occur at edges N+1..N+7.
  - LATCH executes at N+8, so the new digits are visible after edge N+8.
  - `busy` is high from after edge N until edge N+8 (8 cycles).
- The earliest next accepted load is at edge N+9.
- `game_over` blinking:
  - The first blank occurs BLINK_DIV clocks after `game_over` is first sampled high.
  - Each phase then lasts exactly BLINK_DIV clocks.
- A score update during blinking updates `tens_q`/`ones_q` without disturbing the prescaler.
- Reset asserted mid-conversion aborts immediately:
  - state returns to IDLE and the display registers clear to 0.
  - The partial result is discarded.
- Simultaneous `score_load` and `game_over` rise: both take effect independently.

## Structure
- Package `score_display_pkg`:
  - `state_t` enum {IDLE, CONV, LATCH}.
  - `MAX_SCORE = 7'd99`.
  - `SEG_BLANK = 8'h00`.
  - The segment LUT as a constant function `digit_to_seg(logic [3:0])`.
- One sub-module, `seg7_decode`: a combinational 4-bit BCD to 8-bit segment decoder, instantiated twice. BCD inputs above 9 yield `SEG_BLANK`.
- The FSM, double-dabble datapath and blink prescaler live in the top-level `score_display_ctrl`.

## Test plan
- Reset release with no stimulus → `ss0 = 3F`, `ss1 = 00`, `busy = 0`.
- `score_load` with `score_in = 42` → `busy` high for 8 cycles; after edge N+8, `ss1 = 66` and `ss0 = 5B`.
- `score_in = 7` → `ss1 = 00` (leading zero blanked), `ss0 = 07`. `score_in = 120` → `ss1 = 6F`, `ss0 = 6F` (saturated to 99).
- Load 42, then pulse `score_load` with 13 at N+3 → the 13 is ignored and the display shows 42. Load 13 at N+9 → the display shows 13 after N+17.
- `BLINK_DIV = 4`, score 42, `game_over = 1`:
  - digits visible for 4 cycles, blank for 4, repeating;
  - drop `game_over` during a blank phase → digits return on the next edge.
- Assert `reset` at N+4 during a load of 99 → `ss0 = 3F`, `ss1 = 00`, `busy = 0` immediately; a new load of 5 after release shows `ss0 = 6D`.

Source files
------------

// File: rtl/score_display_pkg.sv
// Shared types and constants for the two-digit score display controller.
package score_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam logic [6:0] MAX_SCORE = 7'd99;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Segments a..g on bits 0..6, dp on bit 7 (always off), active-high.
  function automatic logic [7:0] digit_to_seg(logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = 8'h3F;
      4'd1:    seg = 8'h06;
      4'd2:    seg = 8'h5B;
      4'd3:    seg = 8'h4F;
      4'd4:    seg = 8'h66;
      4'd5:    seg = 8'h6D;
      4'd6:    seg = 8'h7D;
      4'd7:    seg = 8'h07;
      4'd8:    seg = 8'h7F;
      4'd9:    seg = 8'h6F;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/score_display_ctrl_seg7_decode.sv
// Combinational BCD digit to seven-segment decoder; non-decimal codes go dark.
module seg7_decode
  import score_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  // Out-of-range BCD shows nothing rather than a garbage glyph.
  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) seg = digit_to_seg(bcd);
  end

endmodule

// File: rtl/score_display_ctrl.sv
// Two-digit score display controller: binary score -> BCD via an iterative
// double-dabble FSM, leading-zero blanked seven-segment outputs, and a
// game-over blink driven by a prescaler.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | display stable; accepts score_load
// CONV  | one double-dabble step per clock, 7 steps (step_q 0..6)
// LATCH | copy converted BCD nibbles into the display registers
module score_display_ctrl
  import score_display_pkg::*;
#(
  parameter int BLINK_DIV = 6_000_000  // clocks per blink phase, must be >= 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] score_in,
  input  logic       score_load,
  input  logic       game_over,
  output logic [7:0] ss0,
  output logic [7:0] ss1,
  output logic       busy
);

  localparam int            PW       = $clog2(BLINK_DIV);
  localparam logic [PW-1:0] DIV_LAST = PW'(BLINK_DIV - 1);

  state_t        state_q, state_nxt;
  logic [6:0]    bin_q, bin_nxt;
  logic [7:0]    bcd_q, bcd_nxt;
  logic [2:0]    step_q, step_nxt;
  logic [3:0]    tens_q, tens_nxt;
  logic [3:0]    ones_q, ones_nxt;
  logic [7:0]    bcd_adj;
  logic [PW-1:0] presc_q;
  logic          phase_q;
  logic [7:0]    seg_tens, seg_ones;

  // FSM state and conversion datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      step_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_nxt;
      bin_q   <= bin_nxt;
      bcd_q   <= bcd_nxt;
      step_q  <= step_nxt;
      tens_q  <= tens_nxt;
      ones_q  <= ones_nxt;
    end
  end

  // Next-state and datapath: capture, add-3/shift steps, then latch.
  always_comb begin
    state_nxt = state_q;
    bin_nxt   = bin_q;
    bcd_nxt   = bcd_q;
    step_nxt  = step_q;
    tens_nxt  = tens_q;
    ones_nxt  = ones_q;

    bcd_adj = bcd_q;
    if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;

    case (state_q)
      IDLE: begin
        if (score_load) begin
          bin_nxt   = (score_in > MAX_SCORE) ? MAX_SCORE : score_in;
          bcd_nxt   = '0;
          step_nxt  = '0;
          state_nxt = CONV;
        end
      end
      CONV: begin
        {bcd_nxt, bin_nxt} = {bcd_adj[6:0], bin_q, 1'b0};
        step_nxt = step_q + 3'd1;
        if (step_q == 3'd6) state_nxt = LATCH;
      end
      LATCH: begin
        tens_nxt  = bcd_q[7:4];
        ones_nxt  = bcd_q[3:0];
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Blink prescaler: runs only while game_over is high, phase flips on wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      phase_q <= 1'b0;
    end else if (!game_over) begin
      presc_q <= '0;
      phase_q <= 1'b0;
    end else if (presc_q == DIV_LAST) begin
      presc_q <= '0;
      phase_q <= ~phase_q;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  seg7_decode u_dec_tens (.bcd(tens_q), .seg(seg_tens));
  seg7_decode u_dec_ones (.bcd(ones_q), .seg(seg_ones));

  // Output gating: blink phase blanks both digits, a zero tens digit is hidden.
  always_comb begin
    ss0 = seg_ones;
    ss1 = seg_tens;
    if (tens_q == 4'd0) ss1 = SEG_BLANK;
    if (phase_q) begin
      ss0 = SEG_BLANK;
      ss1 = SEG_BLANK;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_score_display_ctrl.sv
// Self-checking bench for score_display_ctrl with a short blink period.
module tb_score_display_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] score_in = '0;
  logic       score_load = 1'b0;
  logic       game_over = 1'b0;
  logic [7:0] ss0, ss1;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: shown score, pending score, edges left in conversion,
  // and the number of consecutive edges game_over has been sampled high.
  int m_disp  = 0;
  int m_pend  = 0;
  int m_left  = 0;
  int m_blink = 0;

  always #5 clk = ~clk;

  score_display_ctrl #(.BLINK_DIV(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .score_in   (score_in),
    .score_load (score_load),
    .game_over  (game_over),
    .ss0        (ss0),
    .ss1        (ss1),
    .busy       (busy)
  );

  function automatic logic [7:0] seg_of(int d);
    logic [7:0] lut [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                              8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    return lut[d];
  endfunction

  function automatic bit m_blank();
    return ((m_blink / DIV) % 2) == 1;
  endfunction

  function automatic logic [7:0] exp_ss0();
    return m_blank() ? 8'h00 : seg_of(m_disp % 10);
  endfunction

  function automatic logic [7:0] exp_ss1();
    return (m_blank() || (m_disp / 10) == 0) ? 8'h00 : seg_of(m_disp / 10);
  endfunction

  function automatic logic exp_busy();
    return m_left != 0;
  endfunction

  // Advance the model with the inputs present before the edge, then clock.
  task automatic cycle();
    if (score_load && m_left == 0) begin
      m_pend = (int'(score_in) > 99) ? 99 : int'(score_in);
      m_left = 8;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_disp = m_pend;
    end
    m_blink = game_over ? m_blink + 1 : 0;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_disp = 0; m_pend = 0; m_left = 0; m_blink = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (ss0 !== 8'h3F) begin n_fail++; $display("FAIL reset_ss0: got %h expected 3f", ss0); end
    n_checks++; if (ss1 !== 8'h00) begin n_fail++; $display("FAIL reset_ss1: got %h expected 00", ss1); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b1;
    model_reset();
    repeat (3) cycle();
    n_checks++; if (ss0 !== 8'h3F) begin n_fail++; $display("FAIL idle_ss0: got %h expected 3f", ss0); end
    n_checks++; if (ss1 !== 8'h00) begin n_fail++; $display("FAIL idle_ss1: got %h expected 00", ss1); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  // Load one score, check busy and the old digits for 8 cycles, then the new digits.
  task automatic test_load(input logic [6:0] v, input logic [7:0] e1, input logic [7:0] e0);
    score_in   = v;
    score_load = 1'b1;
    cycle();
    score_load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL load_busy v=%0d cyc=%0d: got %b expected 1", v, i, busy); end
      n_checks++; if (ss0 !== exp_ss0()) begin n_fail++; $display("FAIL load_hold_ss0 v=%0d cyc=%0d: got %h expected %h", v, i, ss0, exp_ss0()); end
      n_checks++; if (ss1 !== exp_ss1()) begin n_fail++; $display("FAIL load_hold_ss1 v=%0d cyc=%0d: got %h expected %h", v, i, ss1, exp_ss1()); end
      cycle();
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL load_done_busy v=%0d: got %b expected 0", v, busy); end
    n_checks++; if (ss1 !== e1) begin n_fail++; $display("FAIL load_ss1 v=%0d: got %h expected %h", v, ss1, e1); end
    n_checks++; if (ss0 !== e0) begin n_fail++; $display("FAIL load_ss0 v=%0d: got %h expected %h", v, ss0, e0); end
  endtask

  // Loads arriving during CONV and LATCH are dropped; the first one after is taken.
  task automatic test_back_to_back();
    score_in = 7'd42; score_load = 1'b1;
    cycle();                                   // edge N
    score_load = 1'b0;
    repeat (2) cycle();                        // N+1, N+2
    score_in = 7'd13; score_load = 1'b1;
    cycle();                                   // N+3, dropped
    score_load = 1'b0;
    repeat (4) cycle();                        // N+4..N+7
    score_in = 7'd55; score_load = 1'b1;
    cycle();                                   // N+8, in LATCH, dropped
    score_load = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_n8: got %b expected 0", busy); end
    n_checks++; if (ss1 !== 8'h66) begin n_fail++; $display("FAIL b2b_ss1_42: got %h expected 66", ss1); end
    n_checks++; if (ss0 !== 8'h5B) begin n_fail++; $display("FAIL b2b_ss0_42: got %h expected 5b", ss0); end
    score_in = 7'd13; score_load = 1'b1;
    cycle();                                   // N+9, accepted
    score_load = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_n9: got %b expected 1", busy); end
    repeat (7) cycle();                        // N+16
    n_checks++; if (ss0 !== 8'h5B) begin n_fail++; $display("FAIL b2b_ss0_n16: got %h expected 5b", ss0); end
    cycle();                                   // N+17
    n_checks++; if (ss1 !== 8'h06) begin n_fail++; $display("FAIL b2b_ss1_13: got %h expected 06", ss1); end
    n_checks++; if (ss0 !== 8'h4F) begin n_fail++; $display("FAIL b2b_ss0_13: got %h expected 4f", ss0); end
  endtask

  task automatic test_blink();
    int guard;
    game_over = 1'b1;
    for (int i = 0; i < 4 * DIV + 3; i++) begin
      cycle();
      n_checks++; if (ss0 !== exp_ss0()) begin n_fail++; $display("FAIL blink_ss0 cyc=%0d: got %h expected %h", i, ss0, exp_ss0()); end
      n_checks++; if (ss1 !== exp_ss1()) begin n_fail++; $display("FAIL blink_ss1 cyc=%0d: got %h expected %h", i, ss1, exp_ss1()); end
    end
    guard = 0;
    while (!m_blank() && guard < 4 * DIV) begin cycle(); guard++; end
    n_checks++; if (ss0 !== 8'h00) begin n_fail++; $display("FAIL blink_blank_ss0: got %h expected 00", ss0); end
    game_over = 1'b0;
    cycle();
    n_checks++; if (ss1 !== 8'h06) begin n_fail++; $display("FAIL blink_return_ss1: got %h expected 06", ss1); end
    n_checks++; if (ss0 !== 8'h4F) begin n_fail++; $display("FAIL blink_return_ss0: got %h expected 4f", ss0); end
  endtask

  // Random loads and game_over toggling against the model, cycle by cycle.
  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) game_over = ~game_over;
      score_load = ($urandom_range(0, 3) == 0);
      score_in   = 7'($urandom_range(0, 127));
      cycle();
      n_checks++; if (busy !== exp_busy()) begin n_fail++; $display("FAIL rand_busy cyc=%0d: got %b expected %b", i, busy, exp_busy()); end
      n_checks++; if (ss0 !== exp_ss0()) begin n_fail++; $display("FAIL rand_ss0 cyc=%0d: got %h expected %h", i, ss0, exp_ss0()); end
      n_checks++; if (ss1 !== exp_ss1()) begin n_fail++; $display("FAIL rand_ss1 cyc=%0d: got %h expected %h", i, ss1, exp_ss1()); end
    end
    score_load = 1'b0;
    game_over  = 1'b0;
    repeat (10) cycle();
  endtask

  // Reset during a conversion clears everything at once; next load works.
  task automatic test_reset_mid();
    score_in = 7'd99; score_load = 1'b1;
    cycle();                                   // edge N
    score_load = 1'b0;
    repeat (4) cycle();                        // N+4
    #2 reset = 1'b0;
    #1;
    n_checks++; if (ss0 !== 8'h3F) begin n_fail++; $display("FAIL rstmid_ss0: got %h expected 3f", ss0); end
    n_checks++; if (ss1 !== 8'h00) begin n_fail++; $display("FAIL rstmid_ss1: got %h expected 00", ss1); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    #2 reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    test_load(7'd5, 8'h00, 8'h6D);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load(7'd42, 8'h66, 8'h5B);
    test_load(7'd7, 8'h00, 8'h07);
    test_load(7'd120, 8'h6F, 8'h6F);
    test_load(7'd0, 8'h00, 8'h3F);
    test_load(7'd90, 8'h6F, 8'h3F);
    test_back_to_back();
    test_blink();
    test_random();
    test_load(7'd42, 8'h66, 8'h5B);
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
